nonce_encoder: RTL and testbench

Work-issue front end of the mining datapath and the transmit-side counterpart of the nonce decoder. On each new block it holds off issue for a fixed broadcast window while header data is distributed to the cores. It then hands out one nonce prefix per accepted round, so each of NUM_CORES cores tests nonce {prefix, core_index}. Issue stops when the nonce space is exhausted or when a success or abort is signalled.

---
 rtl/nonce_encoder.sv | 134 +++++++++++++
 tb/tb_nonce_encoder.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_encoder.sv
// nonce_encoder: work-issue front end. After a block start it holds issue for
// a fixed broadcast window, then hands out one nonce prefix per accepted
// round until the prefix space is exhausted or the block is stopped.
module nonce_encoder #(
   parameter int              NUM_CORES     = 4,
   parameter int              BROADCAST_CNT = 5,
   parameter longint unsigned MAX_PREFIX    = (64'd1 << (32 - $clog2(NUM_CORES))) - 64'd1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start_i,
   input  logic                              stop_i,
   input  logic                              ready_i,
   output logic                              newblock_o,
   output logic                              broadcast_o,
   output logic                              valid_o,
   output logic [31-$clog2(NUM_CORES):0]     nonce_prefix_o,
   output logic                              done_o,
   output logic                              busy_o
);

   localparam int CW  = $clog2(NUM_CORES);
   localparam int PW  = 32 - CW;
   // Counter only ever holds BROADCAST_CNT-1 down to 0.
   localparam int CTW = (BROADCAST_CNT > 1) ? $clog2(BROADCAST_CNT) : 1;

   localparam logic [PW-1:0]  MAX_P    = PW'(MAX_PREFIX);
   localparam logic [CTW-1:0] CNT_LOAD = CTW'(BROADCAST_CNT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BROADCAST,
      S_ISSUE,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [PW-1:0]   r_prefix;
   logic [PW-1:0]   w_prefix_next;
   logic [CTW-1:0]  r_cnt;
   logic [CTW-1:0]  w_cnt_next;
   logic            w_newblock_next;
   logic            w_accept;

   logic            r_newblock;
   logic            r_broadcast;
   logic            r_valid;
   logic            r_done;
   logic            r_busy;

   // A round is taken whenever the cores are ready while a round is presented.
   assign w_accept = (r_state == S_ISSUE) && ready_i;

   // Next-state, prefix and counter logic; start overrides stop and everything else.
   always_comb begin
      w_state_next    = r_state;
      w_prefix_next   = r_prefix;
      w_cnt_next      = r_cnt;
      w_newblock_next = 1'b0;
      if (start_i) begin
         w_state_next    = S_BROADCAST;
         w_prefix_next   = '0;
         w_cnt_next      = CNT_LOAD;
         w_newblock_next = 1'b1;
      end else begin
         // An accepted round advances the prefix even when stop arrives with it;
         // the last prefix never wraps.
         if (w_accept && (r_prefix != MAX_P)) begin
            w_prefix_next = r_prefix + PW'(1);
         end
         case (r_state)
            S_IDLE: begin
               w_state_next = S_IDLE;
            end
            S_BROADCAST: begin
               if (stop_i) begin
                  w_state_next = S_IDLE;
               end else if (r_cnt == '0) begin
                  w_state_next = S_ISSUE;
               end else begin
                  w_cnt_next = r_cnt - CTW'(1);
               end
            end
            S_ISSUE: begin
               if (stop_i) begin
                  w_state_next = S_IDLE;
               end else if (w_accept && (r_prefix == MAX_P)) begin
                  w_state_next = S_DONE;
               end
            end
            S_DONE: begin
               if (stop_i) begin
                  w_state_next = S_IDLE;
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // State register plus registered decode of the next state onto the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_prefix    <= '0;
         r_cnt       <= '0;
         r_newblock  <= 1'b0;
         r_broadcast <= 1'b0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_prefix    <= w_prefix_next;
         r_cnt       <= w_cnt_next;
         r_newblock  <= w_newblock_next;
         r_broadcast <= (w_state_next == S_BROADCAST);
         r_valid     <= (w_state_next == S_ISSUE);
         r_done      <= (w_state_next == S_DONE);
         r_busy      <= (w_state_next == S_BROADCAST) || (w_state_next == S_ISSUE);
      end
   end

   assign newblock_o     = r_newblock;
   assign broadcast_o    = r_broadcast;
   assign valid_o        = r_valid;
   assign nonce_prefix_o = r_prefix;
   assign done_o         = r_done;
   assign busy_o         = r_busy;

endmodule

// File: tb/tb_nonce_encoder.sv
// tb_nonce_encoder: drives two encoders (wide prefix space / 5-cycle window,
// and MAX_PREFIX=3 / 1-cycle window) from shared stimulus and compares each
// against a block-age based reference model every cycle.
module tb_nonce_encoder;

   localparam int              PW    = 30;
   localparam int              CNT_A = 5;
   localparam int              CNT_B = 1;
   localparam longint unsigned MAX_A = 64'h3FFF_FFFF;
   localparam longint unsigned MAX_B = 64'd3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_i = 1'b0;
   logic stop_i = 1'b0;
   logic ready_i = 1'b0;

   logic          a_nb, a_bc, a_valid, a_done, a_busy;
   logic [PW-1:0] a_prefix;
   logic          b_nb, b_bc, b_valid, b_done, b_busy;
   logic [PW-1:0] b_prefix;

   int total = 0;
   int bad   = 0;

   // Reference model: a block is "active" from start until stop/reset; age counts
   // cycles since start (1 = first broadcast cycle), saturating once issuing.
   bit              m_active [2];
   int              m_age    [2];
   longint unsigned m_prefix [2];
   bit              m_done   [2];
   int              cnt_of   [2] = '{CNT_A, CNT_B};
   longint unsigned max_of   [2] = '{MAX_A, MAX_B};

   logic [34:0] obs [2];

   always #5 clk = ~clk;

   nonce_encoder #(.NUM_CORES(4), .BROADCAST_CNT(CNT_A), .MAX_PREFIX(MAX_A)) dut_a (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .ready_i(ready_i),
      .newblock_o(a_nb), .broadcast_o(a_bc), .valid_o(a_valid),
      .nonce_prefix_o(a_prefix), .done_o(a_done), .busy_o(a_busy)
   );

   nonce_encoder #(.NUM_CORES(4), .BROADCAST_CNT(CNT_B), .MAX_PREFIX(MAX_B)) dut_b (
      .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .ready_i(ready_i),
      .newblock_o(b_nb), .broadcast_o(b_bc), .valid_o(b_valid),
      .nonce_prefix_o(b_prefix), .done_o(b_done), .busy_o(b_busy)
   );

   function automatic logic [34:0] pack(logic nb, logic bc, logic v, logic d, logic b,
                                        logic [PW-1:0] p);
      return {nb, bc, v, d, b, (v ? p : {PW{1'b0}})};
   endfunction

   assign obs[0] = pack(a_nb, a_bc, a_valid, a_done, a_busy, a_prefix);
   assign obs[1] = pack(b_nb, b_bc, b_valid, b_done, b_busy, b_prefix);

   function automatic logic [34:0] expected(int k);
      logic act;
      act = m_active[k];
      return pack(act && (m_age[k] == 1),
                  act && (m_age[k] <= cnt_of[k]),
                  act && !m_done[k] && (m_age[k] > cnt_of[k]),
                  act && m_done[k],
                  act && !m_done[k],
                  PW'(m_prefix[k]));
   endfunction

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_active[k] = 0; m_age[k] = 0; m_prefix[k] = 0; m_done[k] = 0;
         end else if (start_i) begin
            m_active[k] = 1; m_age[k] = 1; m_prefix[k] = 0; m_done[k] = 0;
         end else if (stop_i) begin
            m_active[k] = 0; m_done[k] = 0;
         end else if (m_active[k] && !m_done[k]) begin
            if ((m_age[k] > cnt_of[k]) && ready_i) begin
               if (m_prefix[k] == max_of[k]) m_done[k] = 1;
               else m_prefix[k] = m_prefix[k] + 1;
            end
            if (m_age[k] <= cnt_of[k]) m_age[k] = m_age[k] + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b0;
      for (int c = 0; c < 7; c++) begin
         if (c == 2) rst = 1'b0;
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expected(k)) begin
               bad++;
               $display("FAIL reset_model dut%0d c=%0d: got %h want %h", k, c, obs[k], expected(k));
            end
         end
         total++;
         if ({a_prefix, b_prefix} !== '0 || {a_nb, a_bc, a_valid, a_done, a_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_zero c=%0d: got pa=%0d pb=%0d flags=%b want all 0",
                     c, a_prefix, b_prefix, {a_nb, a_bc, a_valid, a_done, a_busy});
         end
      end
      $display("reset/idle checked");
   endtask

   task automatic test_basic_issue();
      ready_i = 1'b1;
      start_i = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         start_i = 1'b0;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expected(k)) begin
               bad++;
               $display("FAIL basic_model dut%0d i=%0d: got %h want %h", k, i, obs[k], expected(k));
            end
         end
         total++;
         if (a_nb !== (i == 1) || a_bc !== (i <= CNT_A) || a_valid !== (i > CNT_A) ||
             (i > CNT_A && a_prefix !== PW'(i - CNT_A - 1))) begin
            bad++;
            $display("FAIL basic_timing i=%0d: got nb=%b bc=%b v=%b p=%0d want nb=%b bc=%b v=%b p=%0d",
                     i, a_nb, a_bc, a_valid, a_prefix, (i == 1), (i <= CNT_A), (i > CNT_A),
                     (i > CNT_A) ? i - CNT_A - 1 : 0);
         end
      end
   endtask

   task automatic test_backpressure();
      int budget;
      budget = 0;
      while (!(a_valid && a_prefix == PW'(7)) && budget < 40) begin
         tick();
         budget++;
      end
      total++;
      if (!(a_valid && a_prefix == PW'(7))) begin
         bad++;
         $display("FAIL backpressure_reach: got v=%b p=%0d want v=1 p=7", a_valid, a_prefix);
      end
      ready_i = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j == 3) ready_i = 1'b1;
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expected(k)) begin
               bad++;
               $display("FAIL backpressure_model dut%0d j=%0d: got %h want %h", k, j, obs[k], expected(k));
            end
         end
         total++;
         if (a_valid !== 1'b1 || a_prefix !== PW'((j == 3) ? 8 : 7)) begin
            bad++;
            $display("FAIL backpressure_hold j=%0d: got v=%b p=%0d want v=1 p=%0d",
                     j, a_valid, a_prefix, (j == 3) ? 8 : 7);
         end
      end
   endtask

   task automatic test_exhaustion();
      logic [PW-1:0] q[$];
      for (int rep = 0; rep < 2; rep++) begin
         q.delete();
         ready_i = 1'b1;
         start_i = 1'b1;
         for (int c = 0; c < 12; c++) begin
            tick();
            start_i = 1'b0;
            if (b_valid && ready_i) begin
               q.push_back(b_prefix);
               $display("round dutB rep=%0d prefix=%0d", rep, b_prefix);
            end
            for (int k = 0; k < 2; k++) begin
               total++;
               if (obs[k] !== expected(k)) begin
                  bad++;
                  $display("FAIL exhaust_model dut%0d c=%0d: got %h want %h", k, c, obs[k], expected(k));
               end
            end
            if (c >= 6) begin
               total++;
               if (b_done !== 1'b1 || b_valid !== 1'b0) begin
                  bad++;
                  $display("FAIL exhaust_done c=%0d: got done=%b v=%b want done=1 v=0", c, b_done, b_valid);
               end
            end
         end
         total++;
         if (q.size() != 4) begin
            bad++;
            $display("FAIL exhaust_count rep=%0d: got %0d rounds want 4", rep, q.size());
         end else begin
            for (int j = 0; j < 4; j++) begin
               total++;
               if (q[j] !== PW'(j)) begin
                  bad++;
                  $display("FAIL exhaust_seq rep=%0d j=%0d: got %0d want %0d", rep, j, q[j], j);
               end
            end
         end
      end
   endtask

   task automatic test_stop();
      int budget;
      budget = 0;
      ready_i = 1'b1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      while (!(a_valid && a_prefix == PW'(5)) && budget < 40) begin
         tick();
         budget++;
      end
      total++;
      if (!(a_valid && a_prefix == PW'(5))) begin
         bad++;
         $display("FAIL stop_reach: got v=%b p=%0d want v=1 p=5", a_valid, a_prefix);
      end
      stop_i = 1'b1;
      tick();
      stop_i = 1'b0;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== expected(k)) begin
            bad++;
            $display("FAIL stop_model dut%0d: got %h want %h", k, obs[k], expected(k));
         end
      end
      total++;
      if ({a_valid, a_busy, a_bc, b_done, b_busy} !== 5'b0) begin
         bad++;
         $display("FAIL stop_idle: got av=%b abusy=%b abc=%b bdone=%b bbusy=%b want all 0",
                  a_valid, a_busy, a_bc, b_done, b_busy);
      end
   endtask

   task automatic test_start_stop();
      start_i = 1'b1;
      stop_i  = 1'b1;
      tick();
      start_i = 1'b0;
      stop_i  = 1'b0;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (obs[k] !== expected(k)) begin
            bad++;
            $display("FAIL startstop_model dut%0d: got %h want %h", k, obs[k], expected(k));
         end
      end
      total++;
      if (a_nb !== 1'b1 || a_bc !== 1'b1) begin
         bad++;
         $display("FAIL startstop_win: got nb=%b bc=%b want nb=1 bc=1", a_nb, a_bc);
      end
   endtask

   task automatic test_restart_mid_broadcast();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      start_i = 1'b1;
      for (int i = 1; i <= CNT_A + 2; i++) begin
         tick();
         start_i = 1'b0;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expected(k)) begin
               bad++;
               $display("FAIL restart_model dut%0d i=%0d: got %h want %h", k, i, obs[k], expected(k));
            end
         end
         total++;
         if (a_nb !== (i == 1) || a_bc !== (i <= CNT_A) || a_valid !== (i > CNT_A)) begin
            bad++;
            $display("FAIL restart_window i=%0d: got nb=%b bc=%b v=%b want nb=%b bc=%b v=%b",
                     i, a_nb, a_bc, a_valid, (i == 1), (i <= CNT_A), (i > CNT_A));
         end
      end
   endtask

   task automatic test_mid_reset();
      int budget;
      budget = 0;
      ready_i = 1'b1;
      while (!(a_valid && a_prefix == PW'(9)) && budget < 40) begin
         tick();
         budget++;
      end
      total++;
      if (!(a_valid && a_prefix == PW'(9))) begin
         bad++;
         $display("FAIL midreset_reach: got v=%b p=%0d want v=1 p=9", a_valid, a_prefix);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({a_nb, a_bc, a_valid, a_done, a_busy, a_prefix} !== '0) begin
         bad++;
         $display("FAIL midreset_zero: got flags=%b p=%0d want all 0",
                  {a_nb, a_bc, a_valid, a_done, a_busy}, a_prefix);
      end
      start_i = 1'b1;
      for (int i = 1; i <= CNT_A + 2; i++) begin
         tick();
         start_i = 1'b0;
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expected(k)) begin
               bad++;
               $display("FAIL midreset_model dut%0d i=%0d: got %h want %h", k, i, obs[k], expected(k));
            end
         end
      end
      total++;
      if (a_valid !== 1'b1 || a_prefix !== PW'(1)) begin
         bad++;
         $display("FAIL midreset_restart: got v=%b p=%0d want v=1 p=1", a_valid, a_prefix);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst     = ($urandom_range(0, 199) == 0);
         start_i = ($urandom_range(0, 29) == 0);
         stop_i  = ($urandom_range(0, 39) == 0);
         ready_i = ($urandom_range(0, 9) < 7);
         tick();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (obs[k] !== expected(k)) begin
               bad++;
               $display("FAIL random_model dut%0d c=%0d: got %h want %h", k, c, obs[k], expected(k));
            end
         end
      end
      rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_active[k] = 0; m_age[k] = 0; m_prefix[k] = 0; m_done[k] = 0;
      end
      test_reset();
      test_basic_issue();
      test_backpressure();
      test_exhaustion();
      test_stop();
      test_start_stop();
      test_restart_mid_broadcast();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
